// File: rtl/fabric_reset_seq_pkg.sv
// Shared types and elaboration helpers for the fabric reset sequencer.
package fabric_reset_seq_pkg;

  localparam int unsigned MAX_STAGES = 16;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HOLD,
    WAIT_READY,
    DONE,
    ERROR
  } seq_state_e;

  // Wide enough for both terminal compares; the compare ends each count before any wrap.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned tmo);
    int unsigned m;
    m = (hold > tmo) ? hold : tmo;
    return 32'($clog2(m)) + 32'd1;
  endfunction

  // Stage index width; a single-stage build still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic bit stages_legal(input int unsigned n);
    return (n >= 32'd1) && (n <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/fabric_reset_seq_sync2.sv
// Two-flop synchronizer with synchronous active-high clear.
module fabric_reset_seq_sync2 (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fabric_reset_sequencer.sv
// Staged release of NUM_STAGES fabric domain resets after a qualified PLL lock.
// Each domain is released only after the previous one acknowledges, with a per-stage timeout.
module fabric_reset_sequencer
  import fabric_reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             PLL_LOCK,
  input  logic                             SOFT_RST_REQ,
  input  logic [NUM_STAGES-1:0]            STAGE_READY,
  output logic [NUM_STAGES-1:0]            DOMAIN_RESET_N,
  output logic                             SEQ_DONE,
  output logic                             SEQ_ERR,
  output logic [idx_width(NUM_STAGES)-1:0] ERR_STAGE
);

  localparam int unsigned IDX_W = idx_width(NUM_STAGES);
  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 32'd1);

  if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
    $error("fabric_reset_sequencer: NUM_STAGES must be within 1..16");
  end
  if (HOLD_CYCLES == 32'd0) begin : g_bad_hold
    $error("fabric_reset_sequencer: HOLD_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 32'd2) begin : g_bad_timeout
    $error("fabric_reset_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  seq_state_e             state, state_nx;
  logic [IDX_W-1:0]       idx, idx_nx, idx_inc;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [CNT_W-1:0]       tcnt, tcnt_nx;
  logic [NUM_STAGES-1:0]  domain_rst_n_nx;
  logic                   done_nx;
  logic                   err_nx;
  logic [IDX_W-1:0]       err_stage_nx;
  logic                   lock_s;
  logic                   ready_q;
  logic                   restart;

  fabric_reset_seq_sync2 u_lock_sync (
    .clk (CLK),
    .clr (RST),
    .d   (PLL_LOCK),
    .q   (lock_s)
  );

  assign idx_inc = idx + 1'b1;

  // Next-state and next-output logic; restart events override every state.
  always_comb begin
    state_nx        = state;
    idx_nx          = idx;
    cnt_nx          = cnt;
    tcnt_nx         = tcnt;
    domain_rst_n_nx = DOMAIN_RESET_N;
    done_nx         = SEQ_DONE;
    err_nx          = SEQ_ERR;
    err_stage_nx    = ERR_STAGE;

    // Only the current stage's ack counts, and only once that domain is out of reset.
    ready_q = STAGE_READY[idx] & DOMAIN_RESET_N[idx];
    restart = (!lock_s && (state != WAIT_LOCK)) || SOFT_RST_REQ;

    if (restart) begin
      state_nx        = WAIT_LOCK;
      idx_nx          = '0;
      cnt_nx          = '0;
      tcnt_nx         = '0;
      domain_rst_n_nx = '0;
      done_nx         = 1'b0;
      err_nx          = 1'b0;
      err_stage_nx    = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = HOLD;
            cnt_nx   = '0;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            domain_rst_n_nx[0] = 1'b1;
            idx_nx             = '0;
            tcnt_nx            = '0;
            state_nx           = WAIT_READY;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        WAIT_READY: begin
          // Ready wins over a timeout landing on the same edge.
          if (ready_q) begin
            if (idx == IDX_LAST) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end else begin
              idx_nx                   = idx_inc;
              domain_rst_n_nx[idx_inc] = 1'b1;
              tcnt_nx                  = '0;
            end
          end else if (tcnt == TMO_LAST) begin
            state_nx        = ERROR;
            err_stage_nx    = idx;
            err_nx          = 1'b1;
            domain_rst_n_nx = '0;
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end
        DONE: begin
          state_nx = DONE;
        end
        ERROR: begin
          state_nx = ERROR;
        end
        default: begin
          state_nx = WAIT_LOCK;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= WAIT_LOCK;
      idx            <= '0;
      cnt            <= '0;
      tcnt           <= '0;
      DOMAIN_RESET_N <= '0;
      SEQ_DONE       <= 1'b0;
      SEQ_ERR        <= 1'b0;
      ERR_STAGE      <= '0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      cnt            <= cnt_nx;
      tcnt           <= tcnt_nx;
      DOMAIN_RESET_N <= domain_rst_n_nx;
      SEQ_DONE       <= done_nx;
      SEQ_ERR        <= err_nx;
      ERR_STAGE      <= err_stage_nx;
    end
  end

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// Directed and randomized bench for fabric_reset_sequencer against a release-count reference model.
module tb_fabric_reset_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned H = 16;
  localparam int unsigned T = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         pll_lock;
  logic         soft_req;
  logic [N-1:0] stage_ready;
  logic [N-1:0] domain_reset_n;
  logic         seq_done;
  logic         seq_err;
  logic [1:0]   err_stage;

  always #5 clk = ~clk;

  fabric_reset_sequencer #(
    .NUM_STAGES     (N),
    .HOLD_CYCLES    (H),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .PLL_LOCK       (pll_lock),
    .SOFT_RST_REQ   (soft_req),
    .STAGE_READY    (stage_ready),
    .DOMAIN_RESET_N (domain_reset_n),
    .SEQ_DONE       (seq_done),
    .SEQ_ERR        (seq_err),
    .ERR_STAGE      (err_stage)
  );

  int checks = 0;
  int errors = 0;
  int edge_n;
  int w;

  // Reference model: number of released domains plus elapsed-time counters.
  bit m_l1, m_l2;
  bit m_active, m_done, m_err;
  int m_rel, m_hold_age, m_wait_age, m_err_stage;

  int           rel_edge [N];
  int           dly      [N];
  bit           auto_rdy;
  logic [N-1:0] force_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_active    = 1'b0;
    m_rel       = 0;
    m_done      = 1'b0;
    m_err       = 1'b0;
    m_err_stage = 0;
    m_hold_age  = 0;
    m_wait_age  = 0;
  endtask

  task automatic model_edge();
    bit lsync;
    lsync = m_l2;
    if (rst) begin
      model_clear();
      m_l1 = 1'b0;
      m_l2 = 1'b0;
      return;
    end
    if ((m_active && !lsync) || soft_req) begin
      model_clear();
    end else if (!m_active) begin
      if (lsync) begin
        m_active   = 1'b1;
        m_hold_age = 0;
      end
    end else if (m_err || m_done) begin
      m_wait_age = m_wait_age;
    end else if (m_rel == 0) begin
      if (m_hold_age == int'(H) - 1) begin
        m_rel      = 1;
        m_wait_age = 0;
      end else begin
        m_hold_age++;
      end
    end else if (stage_ready[m_rel-1]) begin
      if (m_rel == int'(N)) m_done = 1'b1;
      else m_rel++;
      m_wait_age = 0;
    end else if (m_wait_age == int'(T) - 1) begin
      m_err       = 1'b1;
      m_err_stage = m_rel - 1;
      m_rel       = 0;
    end else begin
      m_wait_age++;
    end
    m_l2 = m_l1;
    m_l1 = pll_lock;
  endtask

  function automatic logic [N-1:0] auto_bits();
    logic [N-1:0] b;
    b = '0;
    for (int k = 0; k < int'(N); k++)
      if (m_rel > k && dly[k] != 0 && edge_n + 1 >= rel_edge[k] + dly[k]) b[k] = 1'b1;
    return b;
  endfunction

  task automatic step();
    int prev;
    logic [N-1:0] th;
    logic [N-1:0] thermo_hole;
    prev = m_rel;
    @(posedge clk);
    model_edge();
    edge_n++;
    if (m_rel > prev) rel_edge[m_rel-1] = edge_n;
    #1;
    th = N'((1 << m_rel) - 1);
    check("outputs", 32'({domain_reset_n, seq_done, seq_err, err_stage}),
          32'({th, m_done, m_err, 2'(m_err_stage)}));
    thermo_hole = domain_reset_n & (domain_reset_n + 1'b1);
    check("thermometer", 32'(thermo_hole), 32'd0);
    if (auto_rdy) stage_ready = auto_bits() | force_rdy;
  endtask

  task automatic wait_drn(input logic [N-1:0] target, input string tag);
    int n;
    n = 0;
    while (domain_reset_n !== target && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(domain_reset_n), 32'(target));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (seq_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(seq_done), 32'd1);
  endtask

  task automatic soft_pulse();
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pll_lock = 1'b0; soft_req = 1'b0; stage_ready = '0;
    auto_rdy = 1'b0; force_rdy = '0; edge_n = 0; w = 0;
    m_l1 = 1'b0; m_l2 = 1'b0;
    model_clear();
    for (int k = 0; k < int'(N); k++) rel_edge[k] = 0;
    dly = '{3, 3, 3, 3};

    // Reset state.
    step();
    step();
    check("reset_outputs", 32'({domain_reset_n, seq_done, seq_err, err_stage}), 32'd0);

    // Nominal: lock sampled at edge 10, ready 3 cycles after each release.
    rst = 1'b0; auto_rdy = 1'b1; edge_n = 0;
    for (int i = 1; i <= 9; i++) step();
    pll_lock = 1'b1;
    for (int i = 10; i <= 27; i++) step();
    check("nom_hold_27", 32'(domain_reset_n), 32'h0);
    step();
    check("nom_rel_28", 32'(domain_reset_n), 32'h1);
    repeat (3) step();
    check("nom_rel_31", 32'(domain_reset_n), 32'h3);
    repeat (3) step();
    check("nom_rel_34", 32'(domain_reset_n), 32'h7);
    repeat (3) step();
    check("nom_rel_37", 32'(domain_reset_n), 32'hF);
    repeat (2) step();
    check("nom_done_39", 32'(seq_done), 32'd0);
    step();
    check("nom_done_40", 32'(seq_done), 32'd1);

    // Timeout on stage 2.
    dly = '{2, 2, 0, 0};
    soft_pulse();
    wait_drn(4'b0111, "tmo_stage2_entry");
    repeat (T - 1) step();
    check("tmo_pre_err", 32'(seq_err), 32'd0);
    check("tmo_pre_drn", 32'(domain_reset_n), 32'h7);
    step();
    check("tmo_err", 32'(seq_err), 32'd1);
    check("tmo_err_stage", 32'(err_stage), 32'd2);
    check("tmo_drn", 32'(domain_reset_n), 32'h0);
    force_rdy = '1; stage_ready = '1;
    repeat (3) step();
    check("err_sticky", 32'({seq_err, domain_reset_n}), 32'h10);
    force_rdy = '0;

    // Ready arriving on the last cycle of the window.
    dly = '{2, int'(T), 2, 2};
    soft_pulse();
    wait_drn(4'b0011, "bnd_stage1_entry");
    repeat (T - 1) step();
    check("bnd_pre", 32'(domain_reset_n), 32'h3);
    step();
    check("bnd_release", 32'(domain_reset_n), 32'h7);
    check("bnd_no_err", 32'(seq_err), 32'd0);
    wait_done("bnd_done");

    // Lock loss while waiting on stage 1, then relock.
    dly = '{2, 6, 2, 2};
    soft_pulse();
    wait_drn(4'b0011, "ll_stage1_entry");
    pll_lock = 1'b0;
    step();
    check("ll_f", 32'(domain_reset_n), 32'h3);
    step();
    check("ll_f1", 32'(domain_reset_n), 32'h3);
    step();
    check("ll_f2", 32'(domain_reset_n), 32'h0);
    repeat (3) step();
    check("ll_idle", 32'(domain_reset_n), 32'h0);
    dly = '{2, 2, 2, 0};
    pll_lock = 1'b1;
    for (int i = 1; i <= 18; i++) step();
    check("relock_hold", 32'(domain_reset_n), 32'h0);
    step();
    check("relock_release", 32'(domain_reset_n), 32'h1);

    // Soft request and last-stage ready on the same edge.
    wait_drn(4'b1111, "sim_stage3_entry");
    repeat (2) step();
    soft_req = 1'b1;
    stage_ready = stage_ready | 4'b1000;
    step();
    soft_req = 1'b0;
    check("sim_done", 32'(seq_done), 32'd0);
    check("sim_drn", 32'(domain_reset_n), 32'h0);
    repeat (4) step();
    check("sim_done_after", 32'(seq_done), 32'd0);

    // RST in DONE with out-of-order ready patterns.
    dly = '{2, 2, 2, 2};
    wait_done("rp_done");
    rst = 1'b1; auto_rdy = 1'b0; stage_ready = 4'b1010;
    step();
    check("rp_outputs", 32'({domain_reset_n, seq_done, seq_err, err_stage}), 32'd0);
    step();
    rst = 1'b0; stage_ready = 4'b1110; pll_lock = 1'b1;
    repeat (40) step();
    check("rp_stage0_timeout", 32'({seq_err, err_stage, domain_reset_n}), 32'h40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (pll_lock) begin
        if ($urandom_range(0, 149) == 0) pll_lock = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) pll_lock = 1'b1;
      end
      soft_req    = ($urandom_range(0, 99) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      stage_ready = N'($urandom & $urandom);
      step();
    end
    rst = 1'b0; soft_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
